seg7_scan_driver: RTL and testbench

- Multiplexed seven-segment display driver that consumes the slow divided clock produced by the clock-divider stage as a scan-rate input.
- The block samples that input in the fast system clock domain, detects its rising edges, and steps one digit per edge through a common-anode or common-cathode display.
- Blanking dead-time between digits suppresses ghosting.
- Sits between the clock divider and the board's anode/segment pins.

---
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: steps one digit per rising edge
// of a slow scan tick, with blanking dead-time between digits.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clkIn,
    input  logic                    reset,
    input  logic                    tickIn,
    input  logic [4*NUM_DIGITS-1:0] dataIn,
    input  logic [NUM_DIGITS-1:0]   dpIn,
    input  logic [NUM_DIGITS-1:0]   digitEn,
    output logic [NUM_DIGITS-1:0]   anodeOut,
    output logic [6:0]              segOut,
    output logic                    dpOut
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_SHOW  = 1'b1;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF    = ACTIVE_LOW;

    logic                  s1;
    logic                  s2;
    logic                  p;
    logic                  scan_pulse;
    logic                  state;
    logic [7:0]            blank_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [3:0]            nib;
    logic                  sel_en;
    logic                  sel_dp;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [6:0]            seg_dec;
    logic [NUM_DIGITS-1:0] anode_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    assign scan_pulse = s2 & ~p;

    always_comb begin
        nib        = 4'h0;
        sel_en     = 1'b0;
        sel_dp     = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                nib           = dataIn[4*i +: 4];
                sel_en        = digitEn[i];
                sel_dp        = dpIn[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // active-high gfedcba
    always_comb begin
        case (nib)
            4'h0:    seg_dec = 7'h3F;
            4'h1:    seg_dec = 7'h06;
            4'h2:    seg_dec = 7'h5B;
            4'h3:    seg_dec = 7'h4F;
            4'h4:    seg_dec = 7'h66;
            4'h5:    seg_dec = 7'h6D;
            4'h6:    seg_dec = 7'h7D;
            4'h7:    seg_dec = 7'h07;
            4'h8:    seg_dec = 7'h7F;
            4'h9:    seg_dec = 7'h6F;
            4'hA:    seg_dec = 7'h77;
            4'hB:    seg_dec = 7'h7C;
            4'hC:    seg_dec = 7'h39;
            4'hD:    seg_dec = 7'h5E;
            4'hE:    seg_dec = 7'h79;
            default: seg_dec = 7'h71;
        endcase
    end

    // A disabled digit keeps its full slot but stays dark.
    always_comb begin
        anode_nxt = ANODE_OFF ^ (sel_en ? sel_onehot : '0);
        seg_nxt   = SEG_OFF ^ (sel_en ? seg_dec : 7'h00);
        dp_nxt    = DP_OFF ^ (sel_en & sel_dp);
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            p         <= 1'b0;
            state     <= ST_BLANK;
            blank_cnt <= 8'd0;
            scan_idx  <= '0;
            anodeOut  <= ANODE_OFF;
            segOut    <= SEG_OFF;
            dpOut     <= DP_OFF;
        end else begin
            s1 <= tickIn;
            s2 <= s1;
            p  <= s2;
            case (state)
                ST_BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state     <= ST_SHOW;
                        blank_cnt <= 8'd0;
                        anodeOut  <= anode_nxt;
                        segOut    <= seg_nxt;
                        dpOut     <= dp_nxt;
                    end else begin
                        blank_cnt <= blank_cnt + 8'd1;
                    end
                end
                default: begin
                    if (scan_pulse) begin
                        state    <= ST_BLANK;
                        anodeOut <= ANODE_OFF;
                        segOut   <= SEG_OFF;
                        dpOut    <= DP_OFF;
                        scan_idx <= (scan_idx == IDX_LAST) ? '0
                                    : scan_idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: active-low and active-high copies
// share stimulus; expected digit outputs go through a scoreboard queue.
module tb_seg7_scan_driver;

    typedef struct {
        string      tag;
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clkIn = 1'b0;
    logic        reset = 1'b1;
    logic        tickIn = 1'b0;
    logic [15:0] dataIn = 16'h4321;
    logic [3:0]  dpIn = 4'h0;
    logic [3:0]  digitEn = 4'hF;

    logic [3:0]  anode_lo;
    logic [6:0]  seg_lo;
    logic        dp_lo;
    logic [3:0]  anode_hi;
    logic [6:0]  seg_hi;
    logic        dp_hi;

    int    compared = 0;
    int    mismatched = 0;
    exp_t  sb[$];
    exp_t  cur_e;
    exp_t  off_e;
    int    cur_idx;
    string tag;

    always #5 clkIn = ~clkIn;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clkIn(clkIn), .reset(reset), .tickIn(tickIn),
        .dataIn(dataIn), .dpIn(dpIn), .digitEn(digitEn),
        .anodeOut(anode_lo), .segOut(seg_lo), .dpOut(dp_lo)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clkIn(clkIn), .reset(reset), .tickIn(tickIn),
        .dataIn(dataIn), .dpIn(dpIn), .digitEn(digitEn),
        .anodeOut(anode_hi), .segOut(seg_hi), .dpOut(dp_hi)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                               7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Active-low view of what digit idx should show with current inputs.
    function automatic exp_t mk(input int idx);
        exp_t e;
        logic en;
        logic [3:0] one;
        en = digitEn[idx];
        one = 4'b0001 << idx;
        e.tag = tag;
        e.anode = en ? ~one : 4'hF;
        e.seg = en ? ~hex7(dataIn[4*idx +: 4]) : 7'h7F;
        e.dp = ~(en & dpIn[idx]);
        return e;
    endfunction

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        compared++;
        assert ({anode_lo, seg_lo, dp_lo} === {e.anode, e.seg, e.dp})
        else begin
            mismatched++;
            $error("FAIL %s lo: got a=%h s=%h dp=%b want a=%h s=%h dp=%b",
                   e.tag, anode_lo, seg_lo, dp_lo, e.anode, e.seg, e.dp);
        end
        compared++;
        assert ({anode_hi, seg_hi, dp_hi} === ~{e.anode, e.seg, e.dp})
        else begin
            mismatched++;
            $error("FAIL %s hi: got a=%h s=%h dp=%b want a=%h s=%h dp=%b",
                   e.tag, anode_hi, seg_hi, dp_hi,
                   ~e.anode, ~e.seg, ~e.dp);
        end
    endtask

    task automatic expect_n(input exp_t e, input int n);
        exp_t t;
        t = e;
        t.tag = tag;
        repeat (n) begin
            sb.push_back(t);
            @(negedge clkIn);
            check();
        end
    endtask

    task automatic advance();
        cur_idx = (cur_idx == 3) ? 0 : cur_idx + 1;
        cur_e = mk(cur_idx);
    endtask

    // One tick period: rise shows up 3 edges later as 2 blank cycles.
    task automatic period(input int hi, input int lo);
        tickIn = 1'b1;
        expect_n(cur_e, 2);
        expect_n(off_e, 2);
        advance();
        expect_n(cur_e, hi - 4);
        tickIn = 1'b0;
        expect_n(cur_e, lo);
    endtask

    initial begin
        off_e = '{tag: "off", anode: 4'hF, seg: 7'h7F, dp: 1'b1};

        tag = "in_reset";
        expect_n(off_e, 2);
        reset = 1'b0;
        tag = "rst_rel_blank";
        expect_n(off_e, 1);
        cur_idx = 0;
        cur_e = mk(0);
        tag = "rst_rel_d0";
        expect_n(cur_e, 3);

        tag = "one_tick";
        period(20, 20);

        tag = "five_periods";
        repeat (5) period(20, 20);

        digitEn = 4'b1011;
        dpIn = 4'b0100;
        tag = "dig2_disabled";
        repeat (4) period(6, 4);

        digitEn = 4'hF;
        tag = "dig2_enabled_dp";
        repeat (4) period(6, 4);

        tag = "to_dig0";
        repeat (2) period(6, 4);
        dataIn = 16'hABCD;
        tag = "data_hold_in_show";
        expect_n(cur_e, 5);
        tag = "new_data_next";
        period(6, 4);

        tag = "pulse_in_blank";
        tickIn = 1'b1;
        expect_n(cur_e, 1);
        tickIn = 1'b0;
        expect_n(cur_e, 1);
        tickIn = 1'b1;
        expect_n(off_e, 1);
        tickIn = 1'b0;
        expect_n(off_e, 1);
        advance();
        expect_n(cur_e, 10);

        tag = "async_reset";
        #2 reset = 1'b1;
        #1;
        off_e.tag = tag;
        sb.push_back(off_e);
        check();
        @(negedge clkIn);
        reset = 1'b0;
        tag = "post_reset_blank";
        expect_n(off_e, 1);
        cur_idx = 0;
        cur_e = mk(0);
        tag = "post_reset_d0";
        expect_n(cur_e, 3);

        tag = "post_reset_tick";
        period(8, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
